plot_receiver: RTL and testbench

Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the drawing FSMs. It range-checks each plot request and converts (x, y) to a linear framebuffer address `y*WIDTH + x`. Accepted pixels are buffered in a small FIFO and issued to the framebuffer memory write port under a valid/ack handshake. It sits between the drawing control/datapath blocks and the framebuffer RAM, and gives back-pressure and drop statistics to the drawing side.

---
 rtl/fb_pkg.sv | 11 +
 rtl/plot_fifo.sv | 37 +++
 rtl/plot_receiver.sv | 77 +++++++
 tb/tb_plot_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel entry and output-stage state shared by the plot path.
package fb_pkg;
  localparam int WIDTH = 160;
  localparam int HEIGHT = 120;
  localparam int ADDR_W = 15;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0] colour;
  } pixel_t;
  typedef enum logic {IDLE, WRITE} out_state_e;
endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous FIFO of pixel entries with full/empty flags.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/plot_receiver.sv
// plot_receiver: range-checks plot requests, buffers accepted pixels and issues
// them to the framebuffer write port under a valid/ack handshake.
module plot_receiver
  import fb_pkg::*;
#(
  parameter int WIDTH = fb_pkg::WIDTH,
  parameter int HEIGHT = fb_pkg::HEIGHT,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        colour,
  input  logic              plot,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic              cnt_clr,
  output logic [7:0]        oob_count,
  output logic [7:0]        lost_count
);
  pixel_t pix_in, head, out_q, out_d;
  out_state_e state_q, state_d;
  logic [7:0] oob_q, oob_d, lost_q, lost_d;
  logic full, empty, in_range, accept, push, pop;
  assign in_range = int'(x) < WIDTH && int'(y) < HEIGHT;
  assign accept = plot && ready;
  assign push = accept && in_range;
  // y*160 as y*128 + y*32
  assign pix_in = '{addr: ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x), colour: colour};
  assign ready = !full;
  assign mem_we = state_q == WRITE;
  assign mem_addr = out_q.addr;
  assign mem_data = out_q.colour;
  assign oob_count = oob_q;
  assign lost_count = lost_q;
  plot_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pixel_t))) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push(push),
    .pop(pop),
    .din(pix_in),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    pop = 1'b0;
    if (!empty && (state_q == IDLE || mem_ack)) begin
      pop = 1'b1;
      out_d = head;
      state_d = WRITE;
    end else if (state_q == WRITE && mem_ack) begin
      state_d = IDLE;
    end
    oob_d = cnt_clr ? 8'd0 : (accept && !in_range && oob_q != 8'hff) ? oob_q + 8'd1 : oob_q;
    lost_d = cnt_clr ? 8'd0 : (plot && !ready && lost_q != 8'hff) ? lost_q + 8'd1 : lost_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      out_q <= '0;
      oob_q <= '0;
      lost_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      oob_q <= oob_d;
      lost_q <= lost_d;
    end
endmodule

// File: tb/tb_plot_receiver.sv
// tb_plot_receiver: scoreboard bench for plot_receiver; expected writes are queued at plot time.
module tb_plot_receiver;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic plot = 1'b0, mem_ack = 1'b0, cnt_clr = 1'b0;
  logic ready, mem_we;
  logic [14:0] mem_addr;
  logic [2:0] mem_data;
  logic [7:0] oob_count, lost_count;
  int checks = 0, errors = 0, n_writes = 0;
  logic [17:0] exp_q[$];
  always #5 clk = ~clk;
  plot_receiver dut (
    .clk(clk),
    .resetn(resetn),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .ready(ready),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .mem_ack(mem_ack),
    .cnt_clr(cnt_clr),
    .oob_count(oob_count),
    .lost_count(lost_count)
  );
  // a write completes at the next rising edge whenever we && ack hold here
  always @(negedge clk)
    if (resetn && mem_we && mem_ack) begin
      logic [17:0] e;
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write_order: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   mem_addr, mem_data, e[17:3], e[2:0]);
        end
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int px, input int py, input logic [2:0] c, input bit exp_acc);
    x = 8'(px);
    y = 7'(py);
    colour = c;
    plot = 1'b1;
    if (exp_acc && px < 160 && py < 120) exp_q.push_back({15'(py * 160 + px), c});
    tick();
  endtask
  task automatic test_reset;
    #1;
    checks += 6;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", mem_we); end
    if (mem_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", mem_addr); end
    if (mem_data !== 3'd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", mem_data); end
    if (oob_count !== 8'd0) begin errors++; $display("FAIL reset_oob: got %0d, required 0", oob_count); end
    if (lost_count !== 8'd0) begin errors++; $display("FAIL reset_lost: got %0d, required 0", lost_count); end
    tick();
    tick();
    resetn = 1'b1;
  endtask
  task automatic test_single;
    mem_ack = 1'b1;
    send(10, 5, 3'b101, 1'b1);
    plot = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b, required 0", mem_we); end
    tick();
    checks += 3;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b, required 1", mem_we); end
    if (mem_addr !== 15'd810) begin errors++; $display("FAIL single_addr: got %0d, required 810", mem_addr); end
    if (mem_data !== 3'd5) begin errors++; $display("FAIL single_data: got %0d, required 5", mem_data); end
    tick();
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_len: got %b, required 0", mem_we); end
  endtask
  task automatic test_corners;
    int w0;
    w0 = n_writes;
    send(0, 0, 3'd1, 1'b1);
    send(159, 119, 3'd6, 1'b1);
    send(160, 0, 3'd2, 1'b1);
    send(0, 120, 3'd3, 1'b1);
    plot = 1'b0;
    repeat (6) tick();
    checks += 3;
    if (oob_count !== 8'd2) begin errors++; $display("FAIL corners_oob: got %0d, required 2", oob_count); end
    if (n_writes - w0 != 2) begin errors++; $display("FAIL corners_writes: got %0d, required 2", n_writes - w0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL corners_drain: got %0d pending, required 0", exp_q.size()); end
  endtask
  task automatic test_backpressure;
    mem_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ready !== (i < 5)) begin errors++; $display("FAIL bp_ready%0d: got %b, required %b", i, ready, i < 5); end
      send(i * 3 + 1, i + 2, 3'(i), i < 5);
    end
    plot = 1'b0;
    tick();
    checks++;
    if (lost_count !== 8'd2) begin errors++; $display("FAIL bp_lost: got %0d, required 2", lost_count); end
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL bp_drain%0d: got we=%b, required 1", i, mem_we); end
      tick();
    end
    checks += 2;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL bp_idle: got we=%b, required 0", mem_we); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d, required 0", exp_q.size()); end
  endtask
  task automatic test_reset_mid;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) send(i + 20, i + 1, 3'(i), 1'b0);
    plot = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rmid_pre_we: got %b, required 1", mem_we); end
    #2 resetn = 1'b0;
    #1;
    checks += 4;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b, required 0", mem_we); end
    if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b, required 1", ready); end
    if (oob_count !== 8'd0) begin errors++; $display("FAIL rmid_oob: got %0d, required 0", oob_count); end
    if (lost_count !== 8'd0) begin errors++; $display("FAIL rmid_lost: got %0d, required 0", lost_count); end
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d: got we=%b, required 0", i, mem_we); end
    end
  endtask
  task automatic test_saturate;
    mem_ack = 1'b1;
    x = 8'd200;
    y = 7'd0;
    plot = 1'b1;
    repeat (300) tick();
    checks += 2;
    if (oob_count !== 8'd255) begin errors++; $display("FAIL sat_oob: got %0d, required 255", oob_count); end
    if (lost_count !== 8'd0) begin errors++; $display("FAIL sat_lost: got %0d, required 0", lost_count); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    plot = 1'b0;
    checks++;
    if (oob_count !== 8'd0) begin errors++; $display("FAIL sat_clr: got %0d, required 0", oob_count); end
  endtask
  task automatic test_back_to_back;
    int k;
    for (int i = 0; i < 40; i++) begin
      mem_ack = (i % 2 == 1);
      if (i % 2 == 0) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b, required 1", i, ready); end
        send(int'($urandom_range(159)), int'($urandom_range(119)), 3'($urandom_range(7)), 1'b1);
      end else begin
        plot = 1'b0;
        tick();
      end
    end
    plot = 1'b0;
    mem_ack = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      tick();
      k++;
    end
    tick();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    if (lost_count !== 8'd0) begin errors++; $display("FAIL b2b_lost: got %0d, required 0", lost_count); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_idle: got we=%b, required 0", mem_we); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
